// File: rtl/perceptron_trainer.sv
// Perceptron weight trainer: decides whether to train from the latched prediction,
// then walks weights 0..HISTORY_LENGTH with a read / capture / write sequence.
module perceptron_trainer #(
  parameter int HISTORY_LENGTH    = 15,
  parameter int BIT_WIDTH_WEIGHTS = 8,
  parameter int MEM_ADDR_WIDTH    = 7,
  parameter int SUM_WIDTH         = 11,
  parameter int THRESHOLD         = 42
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [MEM_ADDR_WIDTH-1:0]    base_addr,
  input  logic [HISTORY_LENGTH-1:0]    history,
  input  logic [SUM_WIDTH-1:0]         sum,
  input  logic                         prediction,
  input  logic                         ground_truth,
  output logic                         busy,
  output logic                         done,
  output logic                         trained,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_addr,
  output logic                         mem_wr_en,
  output logic [BIT_WIDTH_WEIGHTS-1:0] mem_wdata,
  input  logic [BIT_WIDTH_WEIGHTS-1:0] mem_rdata
);
  localparam int IDX_W = $clog2(HISTORY_LENGTH + 1);
  localparam int WB    = BIT_WIDTH_WEIGHTS;
  localparam logic [SUM_WIDTH:0] THR      = THRESHOLD[SUM_WIDTH:0];
  localparam logic [IDX_W-1:0]   LAST_IDX = HISTORY_LENGTH[IDX_W-1:0];

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;
  state_t state, state_nxt;

  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic [HISTORY_LENGTH:0]   x_q;      // {history, bias}; bit set means input +1
  logic                      gt_q;
  logic [IDX_W-1:0]          idx;
  logic [WB-1:0]             wdata_q;
  logic                      trained_q;

  logic [SUM_WIDTH:0] sum_ext, sum_abs;
  logic               train, accept, last;

  // One extra bit so the most negative sum has a representable magnitude
  assign sum_ext = {sum[SUM_WIDTH-1], sum};
  assign sum_abs = sum[SUM_WIDTH-1] ? (~sum_ext + 1'b1) : sum_ext;
  assign train   = (prediction != ground_truth) || (sum_abs <= THR);
  assign accept  = (state == S_IDLE) && start;
  assign last    = (idx == LAST_IDX);

  logic          inc;
  logic [WB:0]   w_ext, w_sum;
  logic [WB-1:0] w_new;

  // t*x is +1 exactly when outcome and input agree
  assign inc   = (x_q[idx] == gt_q);
  assign w_ext = {mem_rdata[WB-1], mem_rdata};
  assign w_sum = inc ? (w_ext + 1'b1) : (w_ext - 1'b1);

  always_comb begin
    w_new = w_sum[WB-1:0];
    if (w_sum[WB] != w_sum[WB-1])
      w_new = w_sum[WB] ? {1'b1, {(WB-1){1'b0}}} : {1'b0, {(WB-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = train ? S_RD : S_DONE;
      S_RD:   state_nxt = S_CAP;
      S_CAP:  state_nxt = S_WR;
      S_WR:   state_nxt = last ? S_DONE : S_RD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      x_q       <= '0;
      gt_q      <= 1'b0;
      idx       <= '0;
      wdata_q   <= '0;
      trained_q <= 1'b0;
    end else begin
      if (accept) begin
        base_q    <= base_addr;
        x_q       <= {history, 1'b1};
        gt_q      <= ground_truth;
        idx       <= '0;
        trained_q <= train;
      end
      if (state == S_CAP) wdata_q <= w_new;
      if (state == S_WR && !last) idx <= idx + 1'b1;
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign trained   = trained_q;
  assign mem_addr  = base_q + MEM_ADDR_WIDTH'(idx);
  assign mem_wr_en = (state == S_WR);
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: weight memory, per-cycle reference schedule
// derived from the training rules, directed corner cases and random updates.
module tb_perceptron_trainer;
  localparam int HL = 15, BW = 8, AW = 7, SW = 11, TH = 42;

  logic clk = 1'b0;
  logic rst, start, prediction, ground_truth;
  logic [AW-1:0] base_addr;
  logic [HL-1:0] history;
  logic [SW-1:0] sum;
  logic busy, done, trained, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata, mem_rdata;

  perceptron_trainer #(.HISTORY_LENGTH(HL), .BIT_WIDTH_WEIGHTS(BW), .MEM_ADDR_WIDTH(AW),
                       .SUM_WIDTH(SW), .THRESHOLD(TH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .history(history),
    .sum(sum), .prediction(prediction), .ground_truth(ground_truth), .busy(busy),
    .done(done), .trained(trained), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory with registered read
  logic [BW-1:0] mem [0:127];
  logic [BW-1:0] pl_mem [0:127];
  logic          pl_en;
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (pl_en) for (int a = 0; a < 128; a++) mem[a] <= pl_mem[a];
    else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  // Reference model
  logic [BW-1:0] ref_w [0:127];
  bit            m_valid, m_train, m_gt, m_tr_old, m_tr_new;
  int            m_acc, m_len;
  logic [AW-1:0] m_base;
  logic [HL-1:0] m_hist;
  int            n_cmp = 0, n_bad = 0;
  bit            finished = 0;

  function automatic bit model_idle(int n);
    return !m_valid || (n - m_acc > m_len);
  endfunction

  function automatic bit exp_trained(int n);
    return (m_valid && n > m_acc) ? m_tr_new : m_tr_old;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic scramble();
    base_addr = 7'($urandom); history = 15'($urandom); sum = 11'($urandom);
    prediction = 1'($urandom); ground_truth = 1'($urandom);
  endtask

  // Raise start for one cycle; the model accepts only if the block is idle
  task automatic pulse_start();
    int s;
    start = 1'b1;
    if (!rst && model_idle(cyc)) begin
      s          = int'($signed(sum));
      if (s < 0) s = -s;
      m_tr_old   = exp_trained(cyc);
      m_train    = (prediction != ground_truth) || (s <= TH);
      m_tr_new   = m_train;
      m_valid    = 1'b1;
      m_acc      = cyc;
      m_len      = m_train ? 3 * (HL + 1) + 1 : 1;
      m_base     = base_addr;
      m_hist     = history;
      m_gt       = ground_truth;
    end
    step();
    start = 1'b0;
    scramble();
  endtask

  task automatic run(input logic [AW-1:0] b, input logic [HL-1:0] h, input logic [SW-1:0] s,
                     input logic p, input logic g, input bit noisy,
                     output int dk, output logic tr);
    base_addr = b; history = h; sum = s; prediction = p; ground_truth = g;
    pulse_start();
    dk = 1;
    while (!done && dk < 60) begin
      scramble();
      if (noisy && $urandom_range(0, 7) == 0) pulse_start();
      else step();
      dk++;
    end
    chk("done_seen", done, 1);
    tr = trained;
    step();
  endtask

  task automatic preload();
    pl_en = 1'b1;
    step();
    pl_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; history = '0; sum = '0;
    prediction = 1'b0; ground_truth = 1'b0; pl_en = 1'b0;
    m_valid = 0; m_train = 0; m_gt = 0; m_tr_old = 0; m_tr_new = 0;
    m_acc = 0; m_len = 0; m_base = '0; m_hist = '0;
    fork
      begin : cmp_proc
        int k, i, w, xi;
        logic [AW-1:0] ea;
        logic [BW-1:0] ed;
        bit act, ewr;
        while (!finished) begin
          @(negedge clk);
          if (pl_en) for (int a = 0; a < 128; a++) ref_w[a] = pl_mem[a];
          if (rst) begin
            chk("rst_busy", busy, 0); chk("rst_done", done, 0);
            chk("rst_trained", trained, 0); chk("rst_wr_en", mem_wr_en, 0);
            chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
          end else begin
            k   = cyc - m_acc;
            act = m_valid && k >= 1 && k <= m_len;
            ewr = act && m_train && k < m_len && (k % 3 == 0);
            chk("busy", busy, act);
            chk("done", done, m_valid && k == m_len);
            chk("trained", trained, exp_trained(cyc));
            chk("wr_en", mem_wr_en, ewr);
            if (act && m_train && k < m_len && (k % 3 == 1))
              chk("rd_addr", mem_addr, 7'(m_base + (k - 1) / 3));
            if (ewr) begin
              i  = k / 3 - 1;
              ea = 7'(m_base + i);
              xi = (i == 0) ? 1 : (m_hist[i-1] ? 1 : -1);
              w  = int'($signed(ref_w[ea])) + (m_gt ? xi : -xi);
              if (w > 127) w = 127;
              if (w < -128) w = -128;
              ed = 8'(w);
              chk("wr_addr", mem_addr, ea);
              chk("wr_data", mem_wdata, ed);
              ref_w[ea] = ed;
            end
          end
        end
      end
      begin : stim_proc
        int dk, v;
        logic tr;
        step(); step();
        chk("reset_busy", busy, 0); chk("reset_trained", trained, 0);
        rst = 1'b0;
        for (int a = 0; a < 128; a++) pl_mem[a] = '0;
        preload();

        // Mispredict from all-zero weights
        run(7'h10, 15'h5555, 11'd0, 1'b0, 1'b1, 1'b0, dk, tr);
        chk("mispredict_done_k", dk, 49); chk("mispredict_trained", tr, 1);
        chk("w10", mem[7'h10], 8'h01); chk("w11", mem[7'h11], 8'h01);
        chk("w12", mem[7'h12], 8'hFF); chk("w1F", mem[7'h1F], 8'h01);

        // Confident and correct: no update
        run(7'h20, 15'h1234, 11'd100, 1'b1, 1'b1, 1'b0, dk, tr);
        chk("confident_done_k", dk, 1); chk("confident_trained", tr, 0);

        // Threshold edges
        run(7'h60, 15'h0F0F, 11'd42, 1'b1, 1'b1, 1'b0, dk, tr);
        chk("thr_p42", tr, 1); chk("thr_p42_k", dk, 49);
        run(7'h60, 15'h0F0F, 11'h7D6, 1'b0, 1'b0, 1'b0, dk, tr);
        chk("thr_m42", tr, 1);
        run(7'h60, 15'h0F0F, 11'd43, 1'b1, 1'b1, 1'b0, dk, tr);
        chk("thr_p43", tr, 0); chk("thr_p43_k", dk, 1);
        run(7'h60, 15'h0F0F, 11'h400, 1'b1, 1'b1, 1'b0, dk, tr);
        chk("thr_m1024", tr, 0);
        run(7'h60, 15'h0F0F, 11'd500, 1'b1, 1'b0, 1'b0, dk, tr);
        chk("thr_mispred_big", tr, 1);

        // Saturation at both rails and address wrap
        for (int a = 0; a < 128; a++) pl_mem[a] = ref_w[a];
        for (int a = 0; a < 16; a++) pl_mem[(8'h78 + a) % 128] = 8'h7F;
        for (int a = 0; a < 16; a++) pl_mem[8'h30 + a] = 8'h80;
        pl_mem[8] = 8'h55;
        preload();
        run(7'h78, 15'h7FFF, 11'd0, 1'b0, 1'b1, 1'b0, dk, tr);
        chk("sat_w78", mem[7'h78], 8'h7F); chk("sat_w07", mem[7'h07], 8'h7F);
        chk("wrap_w08_untouched", mem[7'h08], 8'h55);
        run(7'h30, 15'h7FFF, 11'd0, 1'b1, 1'b0, 1'b0, dk, tr);
        chk("sat_w30", mem[7'h30], 8'h80); chk("sat_w3F", mem[7'h3F], 8'h80);

        // Start while busy, then reset mid-update
        base_addr = 7'h40; history = '0; sum = '0; prediction = 1'b0; ground_truth = 1'b1;
        pulse_start();
        repeat (9) step();
        scramble(); base_addr = 7'h50;
        pulse_start();
        repeat (9) step();
        rst = 1'b1; m_valid = 0; m_tr_old = 0;
        #1;
        chk("abort_busy", busy, 0); chk("abort_wr_en", mem_wr_en, 0);
        chk("abort_addr", mem_addr, 0); chk("abort_wdata", mem_wdata, 0);
        step(); step(); step();
        rst = 1'b0;
        step();
        chk("abort_w40", mem[7'h40], 8'h01); chk("abort_w45", mem[7'h45], 8'hFF);
        chk("abort_w46", mem[7'h46], 8'h00); chk("ignored_w50", mem[7'h50], 8'h00);
        run(7'h40, 15'h0000, 11'd0, 1'b0, 1'b1, 1'b0, dk, tr);
        chk("after_rst_k", dk, 49);
        chk("after_rst_w40", mem[7'h40], 8'h02); chk("after_rst_w46", mem[7'h46], 8'hFF);

        // Random updates over a weight table biased toward the rails
        for (int a = 0; a < 128; a++)
          case ($urandom_range(0, 3))
            0: pl_mem[a] = 8'h7F;
            1: pl_mem[a] = 8'h80;
            default: pl_mem[a] = 8'($urandom);
          endcase
        preload();
        for (int n = 0; n < 60; n++) begin
          case ($urandom_range(0, 3))
            0: sum = 11'($urandom);
            1: begin
              v = $urandom_range(38, 46);
              sum = $urandom_range(0, 1) ? 11'(v) : 11'(-v);
            end
            2: sum = 11'h400;
            default: sum = '0;
          endcase
          run(7'($urandom), 15'($urandom), sum, 1'($urandom), 1'($urandom), 1'b1, dk, tr);
          repeat ($urandom_range(0, 2)) step();
        end
        step(); step();
        for (int a = 0; a < 128; a++) chk($sformatf("mem_final[%0h]", a), mem[a], ref_w[a]);
        finished = 1;
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
